// File: rtl/trap_seq_if.sv
// Bundle of trap/mret requests, EXU CSR writes, CSR-file port and IFU redirect.
// No latency of its own; pure wiring between the sequencer and its neighbours.
// Handshakes are valid/ready (trap, mret, redirect) and req/gnt (EXU CSR write).
// master: the sequencer side (drives readies, grant, CSR port, redirect).
// slave : EXU/WBU, CSR file and IFU side (drives requests, csr_rdata, redirect_ready).
interface trap_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  trap_valid;
    logic                  trap_ready;
    logic [DATA_WIDTH-1:0] trap_cause;
    logic [DATA_WIDTH-1:0] trap_pc;
    logic                  mret_valid;
    logic                  mret_ready;
    logic                  exu_csr_req;
    logic [ADDR_WIDTH-1:0] exu_csr_addr;
    logic [DATA_WIDTH-1:0] exu_csr_wdata;
    logic                  exu_csr_gnt;
    logic [ADDR_WIDTH-1:0] csr_raddr;
    logic [DATA_WIDTH-1:0] csr_rdata;
    logic                  csr_wen;
    logic [ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic                  redirect_valid;
    logic                  redirect_ready;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  busy;

    modport master (
        input  trap_valid, trap_cause, trap_pc, mret_valid,
               exu_csr_req, exu_csr_addr, exu_csr_wdata,
               csr_rdata, redirect_ready,
        output trap_ready, mret_ready, exu_csr_gnt,
               csr_raddr, csr_wen, csr_waddr, csr_wdata,
               redirect_valid, redirect_pc, busy
    );

    modport slave (
        output trap_valid, trap_cause, trap_pc, mret_valid,
               exu_csr_req, exu_csr_addr, exu_csr_wdata,
               csr_rdata, redirect_ready,
        input  trap_ready, mret_ready, exu_csr_gnt,
               csr_raddr, csr_wen, csr_waddr, csr_wdata,
               redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_seq.sv
// Trap/mret sequencer owning the single machine-mode CSR write port; idles as an EXU write arbiter.
// Latency: trap -> redirect in 5 cycles, mret -> redirect in 3 cycles; EXU writes pass through in 0 cycles.
// Backpressure: REDIR holds redirect_valid/redirect_pc until redirect_ready; no requests accepted while busy.
// Ports: clk, rst (async active-low), bus (trap_seq_if.master: requests, CSR port, redirect, busy).
module trap_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic            clk,
    input  logic            rst,
    trap_seq_if.master      bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] T_EPC   = 3'd1;
    localparam logic [2:0] T_CAUSE = 3'd2;
    localparam logic [2:0] T_STAT  = 3'd3;
    localparam logic [2:0] T_VEC   = 3'd4;
    localparam logic [2:0] M_STAT  = 3'd5;
    localparam logic [2:0] M_EPC   = 3'd6;
    localparam logic [2:0] REDIR   = 3'd7;

    localparam logic [ADDR_WIDTH-1:0] CSR_MSTATUS = ADDR_WIDTH'(12'h300);
    localparam logic [ADDR_WIDTH-1:0] CSR_MTVEC   = ADDR_WIDTH'(12'h305);
    localparam logic [ADDR_WIDTH-1:0] CSR_MEPC    = ADDR_WIDTH'(12'h341);
    localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE  = ADDR_WIDTH'(12'h342);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] cause_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] target_q;
    logic [DATA_WIDTH-1:0] aligned_rdata;

    // Direct-mode target: low two bits of mtvec/mepc are never part of the PC.
    assign aligned_rdata = {bus.csr_rdata[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        bus.trap_ready     = 1'b0;
        bus.mret_ready     = 1'b0;
        bus.exu_csr_gnt    = 1'b0;
        bus.csr_raddr      = '0;
        bus.csr_wen        = 1'b0;
        bus.csr_waddr      = '0;
        bus.csr_wdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.busy           = (state != IDLE);
        case (state)
            IDLE: begin
                // Gated by rst so the combinational accepts read 0 while reset is held.
                if (rst) begin
                    bus.trap_ready  = bus.trap_valid;
                    bus.mret_ready  = bus.mret_valid & ~bus.trap_valid;
                    bus.exu_csr_gnt = bus.exu_csr_req & ~bus.trap_valid & ~bus.mret_valid;
                    if (bus.exu_csr_gnt) begin
                        bus.csr_wen   = 1'b1;
                        bus.csr_waddr = bus.exu_csr_addr;
                        bus.csr_wdata = bus.exu_csr_wdata;
                    end
                end
            end
            T_EPC: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MEPC;
                bus.csr_wdata = pc_q;
            end
            T_CAUSE: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MCAUSE;
                bus.csr_wdata = cause_q;
            end
            T_STAT: begin
                // MPIE <- MIE, MIE <- 0, MPP <- M; everything else preserved.
                bus.csr_raddr     = CSR_MSTATUS;
                bus.csr_wen       = 1'b1;
                bus.csr_waddr     = CSR_MSTATUS;
                bus.csr_wdata     = bus.csr_rdata;
                bus.csr_wdata[7]  = bus.csr_rdata[3];
                bus.csr_wdata[3]  = 1'b0;
                bus.csr_wdata[12:11] = 2'b11;
            end
            T_VEC: begin
                bus.csr_raddr = CSR_MTVEC;
            end
            M_STAT: begin
                // MIE <- MPIE, MPIE <- 1, MPP <- M; everything else preserved.
                bus.csr_raddr     = CSR_MSTATUS;
                bus.csr_wen       = 1'b1;
                bus.csr_waddr     = CSR_MSTATUS;
                bus.csr_wdata     = bus.csr_rdata;
                bus.csr_wdata[3]  = bus.csr_rdata[7];
                bus.csr_wdata[7]  = 1'b1;
                bus.csr_wdata[12:11] = 2'b11;
            end
            M_EPC: begin
                bus.csr_raddr = CSR_MEPC;
            end
            REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cause_q  <= '0;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.trap_valid) begin
                        cause_q <= bus.trap_cause;
                        pc_q    <= bus.trap_pc;
                        state   <= T_EPC;
                    end else if (bus.mret_valid) begin
                        state <= M_STAT;
                    end
                end
                T_EPC:   state <= T_CAUSE;
                T_CAUSE: state <= T_STAT;
                T_STAT:  state <= T_VEC;
                T_VEC: begin
                    target_q <= aligned_rdata;
                    state    <= REDIR;
                end
                M_STAT:  state <= M_EPC;
                M_EPC: begin
                    target_q <= aligned_rdata;
                    state    <= REDIR;
                end
                REDIR: begin
                    if (bus.redirect_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: reset, trap, mret, arbitration priority, redirect stall, abort.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
// The CSR file is stood in for by three registers feeding csr_rdata combinationally.
module tb_trap_seq;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic [31:0] mstatus_v;
    logic [31:0] mtvec_v;
    logic [31:0] mepc_v;

    trap_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    trap_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.csr_rdata = 32'h0;
        case (bus.csr_raddr)
            12'h300: bus.csr_rdata = mstatus_v;
            12'h305: bus.csr_rdata = mtvec_v;
            12'h341: bus.csr_rdata = mepc_v;
            default: bus.csr_rdata = 32'h0;
        endcase
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mstatus_v = 32'h1800;
        bus.trap_valid = 1'b1;   // must not leak through to trap_ready during reset
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests_run++;
        if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin
            tests_failed++; $display("FAIL reset_redirect: got v=%b pc=%h want 0/0", bus.redirect_valid, bus.redirect_pc);
        end
        tests_run++;
        if (bus.csr_wen !== 1'b0 || bus.csr_waddr !== 12'h0 || bus.csr_wdata !== 32'h0 || bus.csr_raddr !== 12'h0) begin
            tests_failed++; $display("FAIL reset_csr: got wen=%b wa=%h wd=%h ra=%h want all 0",
                                     bus.csr_wen, bus.csr_waddr, bus.csr_wdata, bus.csr_raddr);
        end
        tests_run++;
        if (bus.trap_ready !== 1'b0 || bus.mret_ready !== 1'b0 || bus.exu_csr_gnt !== 1'b0) begin
            tests_failed++; $display("FAIL reset_accepts: got tr=%b mr=%b g=%b want 0",
                                     bus.trap_ready, bus.mret_ready, bus.exu_csr_gnt);
        end
        cyc();
        bus.trap_valid = 1'b0;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_trap();
        mstatus_v = 32'h1888;
        mtvec_v   = 32'h80000101;
        bus.redirect_ready = 1'b1;
        bus.trap_valid = 1'b1;
        bus.trap_cause = 32'hb;
        bus.trap_pc    = 32'h80000010;
        @(negedge clk);
        tests_run++;
        if (bus.trap_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL trap_accept: got ready=%b busy=%b want 1/0", bus.trap_ready, bus.busy);
        end
        cyc();
        bus.trap_valid = 1'b0;
        bus.trap_cause = 32'h0;
        bus.trap_pc    = 32'h0;
        @(negedge clk);   // cycle 1
        tests_run++;
        if (bus.csr_wen !== 1'b1 || bus.csr_waddr !== 12'h341 || bus.csr_wdata !== 32'h80000010 || bus.busy !== 1'b1) begin
            tests_failed++; $display("FAIL trap_mepc: got wen=%b wa=%h wd=%h busy=%b want 1/341/80000010/1",
                                     bus.csr_wen, bus.csr_waddr, bus.csr_wdata, bus.busy);
        end
        cyc();
        @(negedge clk);   // cycle 2
        tests_run++;
        if (bus.csr_wen !== 1'b1 || bus.csr_waddr !== 12'h342 || bus.csr_wdata !== 32'hb) begin
            tests_failed++; $display("FAIL trap_mcause: got wen=%b wa=%h wd=%h want 1/342/0000000b",
                                     bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
        end
        cyc();
        @(negedge clk);   // cycle 3
        tests_run++;
        if (bus.csr_raddr !== 12'h300 || bus.csr_wen !== 1'b1 || bus.csr_waddr !== 12'h300 || bus.csr_wdata !== 32'h1880) begin
            tests_failed++; $display("FAIL trap_mstatus: got ra=%h wen=%b wa=%h wd=%h want 300/1/300/00001880",
                                     bus.csr_raddr, bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
        end
        cyc();
        @(negedge clk);   // cycle 4
        tests_run++;
        if (bus.csr_raddr !== 12'h305 || bus.csr_wen !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            tests_failed++; $display("FAIL trap_mtvec_read: got ra=%h wen=%b rv=%b want 305/0/0",
                                     bus.csr_raddr, bus.csr_wen, bus.redirect_valid);
        end
        cyc();
        @(negedge clk);   // cycle 5
        tests_run++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80000100 || bus.csr_wen !== 1'b0) begin
            tests_failed++; $display("FAIL trap_redirect: got rv=%b pc=%h wen=%b want 1/80000100/0",
                                     bus.redirect_valid, bus.redirect_pc, bus.csr_wen);
        end
        cyc();
        @(negedge clk);   // cycle 6
        tests_run++;
        if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            tests_failed++; $display("FAIL trap_idle: got busy=%b rv=%b want 0/0", bus.busy, bus.redirect_valid);
        end
        cyc();
    endtask

    task automatic test_mret();
        mstatus_v = 32'h1880;
        mepc_v    = 32'h80000014;
        bus.redirect_ready = 1'b1;
        bus.mret_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.mret_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mret_accept: got %b want 1", bus.mret_ready);
        end
        cyc();
        bus.mret_valid = 1'b0;
        @(negedge clk);   // cycle 1
        tests_run++;
        if (bus.csr_wen !== 1'b1 || bus.csr_waddr !== 12'h300 || bus.csr_wdata !== 32'h1888 || bus.mret_ready !== 1'b0) begin
            tests_failed++; $display("FAIL mret_mstatus: got wen=%b wa=%h wd=%h mr=%b want 1/300/00001888/0",
                                     bus.csr_wen, bus.csr_waddr, bus.csr_wdata, bus.mret_ready);
        end
        cyc();
        @(negedge clk);   // cycle 2
        tests_run++;
        if (bus.csr_raddr !== 12'h341 || bus.csr_wen !== 1'b0) begin
            tests_failed++; $display("FAIL mret_mepc_read: got ra=%h wen=%b want 341/0", bus.csr_raddr, bus.csr_wen);
        end
        cyc();
        @(negedge clk);   // cycle 3
        tests_run++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80000014) begin
            tests_failed++; $display("FAIL mret_redirect: got rv=%b pc=%h want 1/80000014",
                                     bus.redirect_valid, bus.redirect_pc);
        end
        cyc();
        @(negedge clk);   // cycle 4
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL mret_idle: got busy=%b want 0", bus.busy);
        end
        cyc();
    endtask

    task automatic test_priority();
        mstatus_v = 32'h0000_0008;
        mtvec_v   = 32'h0000_4002;
        mepc_v    = 32'h0000_1230;
        bus.redirect_ready = 1'b1;
        bus.trap_valid    = 1'b1;
        bus.trap_cause    = 32'h2;
        bus.trap_pc       = 32'h0000_0400;
        bus.mret_valid    = 1'b1;
        bus.exu_csr_req   = 1'b1;
        bus.exu_csr_addr  = 12'h340;
        bus.exu_csr_wdata = 32'hdeadbeef;
        @(negedge clk);
        tests_run++;
        if (bus.trap_ready !== 1'b1 || bus.mret_ready !== 1'b0 || bus.exu_csr_gnt !== 1'b0 || bus.csr_wen !== 1'b0) begin
            tests_failed++; $display("FAIL prio_accept: got tr=%b mr=%b g=%b wen=%b want 1/0/0/0",
                                     bus.trap_ready, bus.mret_ready, bus.exu_csr_gnt, bus.csr_wen);
        end
        cyc();
        bus.trap_valid  = 1'b0;
        bus.exu_csr_req = 1'b0;
        @(negedge clk);   // cycle 1: mret still pending but not accepted
        tests_run++;
        if (bus.mret_ready !== 1'b0 || bus.csr_waddr !== 12'h341 || bus.csr_wdata !== 32'h400) begin
            tests_failed++; $display("FAIL prio_busy_mret: got mr=%b wa=%h wd=%h want 0/341/00000400",
                                     bus.mret_ready, bus.csr_waddr, bus.csr_wdata);
        end
        cyc(); cyc();
        @(negedge clk);   // cycle 3: MIE=1 -> MPIE=1, MIE=0, MPP=11
        tests_run++;
        if (bus.csr_wdata !== 32'h1880) begin
            tests_failed++; $display("FAIL prio_mstatus: got %h want 00001880", bus.csr_wdata);
        end
        cyc(); cyc();
        @(negedge clk);   // cycle 5
        tests_run++;
        if (bus.redirect_pc !== 32'h4000 || bus.mret_ready !== 1'b0) begin
            tests_failed++; $display("FAIL prio_redirect: got pc=%h mr=%b want 00004000/0", bus.redirect_pc, bus.mret_ready);
        end
        cyc();
        @(negedge clk);   // cycle 6: first IDLE cycle takes the pending mret
        tests_run++;
        if (bus.mret_ready !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL prio_mret_b2b: got mr=%b busy=%b want 1/0", bus.mret_ready, bus.busy);
        end
        cyc();
        bus.mret_valid = 1'b0;
        mstatus_v = 32'h1880;
        @(negedge clk);
        tests_run++;
        if (bus.csr_waddr !== 12'h300 || bus.csr_wdata !== 32'h1888) begin
            tests_failed++; $display("FAIL prio_mret_stat: got wa=%h wd=%h want 300/00001888", bus.csr_waddr, bus.csr_wdata);
        end
        cyc(); cyc();
        @(negedge clk);
        tests_run++;
        if (bus.redirect_pc !== 32'h1230) begin
            tests_failed++; $display("FAIL prio_mret_redirect: got %h want 00001230", bus.redirect_pc);
        end
        cyc();
    endtask

    task automatic test_stall();
        mstatus_v = 32'h1880;
        mepc_v    = 32'h0000_0203;
        bus.redirect_ready = 1'b0;
        bus.mret_valid = 1'b1;
        cyc();
        bus.mret_valid = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200 || bus.busy !== 1'b1) begin
                tests_failed++; $display("FAIL stall_hold[%0d]: got rv=%b pc=%h busy=%b want 1/00000200/1",
                                         i, bus.redirect_valid, bus.redirect_pc, bus.busy);
            end
            cyc();
        end
        bus.redirect_ready = 1'b1;
        cyc();
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            tests_failed++; $display("FAIL stall_release: got busy=%b rv=%b want 0/0", bus.busy, bus.redirect_valid);
        end
        cyc();
    endtask

    task automatic test_abort();
        bus.redirect_ready = 1'b1;
        bus.trap_valid = 1'b1;
        bus.trap_cause = 32'h5;
        bus.trap_pc    = 32'h0000_0800;
        cyc();
        bus.trap_valid = 1'b0;
        cyc();
        @(negedge clk);   // T_CAUSE
        tests_run++;
        if (bus.csr_waddr !== 12'h342 || bus.csr_wdata !== 32'h5) begin
            tests_failed++; $display("FAIL abort_pre: got wa=%h wd=%h want 342/00000005", bus.csr_waddr, bus.csr_wdata);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.csr_wen !== 1'b0 || bus.csr_waddr !== 12'h0 || bus.csr_wdata !== 32'h0) begin
            tests_failed++; $display("FAIL abort_async: got busy=%b wen=%b wa=%h wd=%h want 0/0/0/0",
                                     bus.busy, bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
        end
        cyc();
        rst = 1'b1;
        bus.exu_csr_req   = 1'b1;
        bus.exu_csr_addr  = 12'h305;
        bus.exu_csr_wdata = 32'h80000000;
        @(negedge clk);
        tests_run++;
        if (bus.exu_csr_gnt !== 1'b1 || bus.csr_wen !== 1'b1 || bus.csr_waddr !== 12'h305 || bus.csr_wdata !== 32'h80000000) begin
            tests_failed++; $display("FAIL abort_exu_write: got g=%b wen=%b wa=%h wd=%h want 1/1/305/80000000",
                                     bus.exu_csr_gnt, bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
        end
        cyc();
        bus.exu_csr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++; $display("FAIL abort_no_redirect[%0d]: got rv=%b busy=%b want 0/0",
                                         i, bus.redirect_valid, bus.busy);
            end
            cyc();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        mstatus_v = 32'h0;
        mtvec_v   = 32'h0;
        mepc_v    = 32'h0;
        bus.trap_valid     = 1'b0;
        bus.trap_cause     = 32'h0;
        bus.trap_pc        = 32'h0;
        bus.mret_valid     = 1'b0;
        bus.exu_csr_req    = 1'b0;
        bus.exu_csr_addr   = 12'h0;
        bus.exu_csr_wdata  = 32'h0;
        bus.redirect_ready = 1'b0;

        test_reset();
        test_trap();
        test_mret();
        test_priority();
        test_stall();
        test_abort();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
